error_latch_controller: RTL and testbench

//   Manages N_CH sticky hold-error channels: latches masked error inputs, drives a per-channel

---
 rtl/error_latch_controller_pkg.sv | 7 +
 rtl/err_rr_arbiter.sv | 28 ++
 rtl/error_latch_controller.sv | 87 ++++++++
 tb/tb_error_latch_controller.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/error_latch_controller_pkg.sv
// err_ctrl_pkg: shared types and helpers for the error latch controller
package err_ctrl_pkg;
  typedef enum logic {IDLE, TEST} lt_state_t;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/err_rr_arbiter.sv
// err_rr_arbiter: picks the first pending channel at or after the pointer, wrapping N-1 -> 0
module err_rr_arbiter
  import err_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        i_pending,
  input  logic [ch_w(N)-1:0]  i_ptr,
  output logic                o_grant_valid,
  output logic [ch_w(N)-1:0]  o_grant_idx
);
  localparam int W = ch_w(N);
  logic [W-1:0] w_idx [N];
  for (genvar g = 0; g < N; g++) begin : g_idx
    assign w_idx[g] = (int'(i_ptr) + g >= N) ? W'(int'(i_ptr) + g - N) : W'(int'(i_ptr) + g);
  end
  // scan from the farthest offset down so the nearest pending channel wins
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_pending[w_idx[k]]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = w_idx[k];
      end
    end
  end
endmodule

// File: rtl/error_latch_controller.sv
// error_latch_controller: sticky error latches, alarm lamps, once-only event reporting,
// host clears and a timed lamp test
module error_latch_controller
  import err_ctrl_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int TEST_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_CH-1:0]         err_in,
  input  logic [N_CH-1:0]         err_mask,
  input  logic                    lamp_test_req,
  input  logic                    clr_req,
  input  logic [ch_w(N_CH)-1:0]   clr_ch,
  input  logic                    evt_ready,
  output logic                    evt_valid,
  output logic [ch_w(N_CH)-1:0]   evt_ch,
  output logic                    clr_ack,
  output logic [N_CH-1:0]         latched,
  output logic [N_CH-1:0]         LA,
  output logic                    test_busy,
  output logic                    any_err
);
  localparam int W  = ch_w(N_CH);
  localparam int CW = ch_w(TEST_CYCLES);
  logic [N_CH-1:0] r_latched, r_pending;
  logic [W-1:0]    r_ptr, r_evt_ch;
  logic            r_evt_valid, r_clr_ack;
  lt_state_t       r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [N_CH-1:0] w_set, w_clr, w_rise, w_ack;
  logic [W-1:0]    w_ptr_nxt, w_grant_idx;
  logic            w_hs, w_grant_valid, w_last;
  err_rr_arbiter #(.N(N_CH)) u_arb (
    .i_pending    (r_pending),
    .i_ptr        (r_ptr),
    .o_grant_valid(w_grant_valid),
    .o_grant_idx  (w_grant_idx)
  );
  assign w_set     = err_in & ~err_mask;
  assign w_clr     = (clr_req && int'(clr_ch) < N_CH) ? (N_CH'(1) << clr_ch) : '0;
  assign w_rise    = w_set & ~r_latched;
  assign w_hs      = r_evt_valid & evt_ready;
  assign w_ack     = w_hs ? (N_CH'(1) << r_evt_ch) : '0;
  assign w_ptr_nxt = (int'(r_evt_ch) == N_CH - 1) ? '0 : r_evt_ch + 1'b1;
  assign w_last    = (int'(r_cnt) == TEST_CYCLES - 1);
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_state_nxt = (r_state == IDLE) ? (lamp_test_req ? TEST : IDLE) : (w_last ? IDLE : TEST);
    w_cnt_nxt   = (r_state == TEST && !w_last) ? r_cnt + 1'b1 : '0;
  end
  // set beats clear on the same channel; a new rising edge beats an acknowledge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_latched   <= '0;
      r_pending   <= '0;
      r_ptr       <= '0;
      r_evt_ch    <= '0;
      r_evt_valid <= 1'b0;
      r_clr_ack   <= 1'b0;
      r_state     <= IDLE;
      r_cnt       <= '0;
    end else begin
      r_latched <= (r_latched & ~w_clr) | w_set;
      r_pending <= (r_pending & ~w_ack) | w_rise;
      r_clr_ack <= clr_req;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      if (w_hs) begin
        r_evt_valid <= 1'b0;
        r_ptr       <= w_ptr_nxt;
      end else if (!r_evt_valid && w_grant_valid) begin
        r_evt_valid <= 1'b1;
        r_evt_ch    <= w_grant_idx;
      end
    end
  end
  assign evt_valid = r_evt_valid;
  assign evt_ch    = r_evt_ch;
  assign clr_ack   = r_clr_ack;
  assign latched   = r_latched;
  assign test_busy = (r_state == TEST);
  assign LA        = r_latched | {N_CH{test_busy}};
  assign any_err   = |r_latched;
endmodule

// File: tb/tb_error_latch_controller.sv
// tb_error_latch_controller: randomized bench with a behavioural model and an event scoreboard
module tb_error_latch_controller;
  localparam int N  = 4;
  localparam int TC = 16;
  logic       clk = 1'b0, reset_n = 1'b0;
  logic [3:0] err_in = '0, err_mask = '0;
  logic       lamp_test_req = 1'b0, clr_req = 1'b0, evt_ready = 1'b0;
  logic [1:0] clr_ch = '0;
  logic       evt_valid, clr_ack, test_busy, any_err;
  logic [1:0] evt_ch;
  logic [3:0] latched, LA;
  always #5 clk = ~clk;
  error_latch_controller #(.N_CH(N), .TEST_CYCLES(TC)) dut (
    .clk(clk), .reset_n(reset_n), .err_in(err_in), .err_mask(err_mask),
    .lamp_test_req(lamp_test_req), .clr_req(clr_req), .clr_ch(clr_ch), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_ch(evt_ch), .clr_ack(clr_ack), .latched(latched), .LA(LA),
    .test_busy(test_busy), .any_err(any_err)
  );
  bit   m_lat[N], m_pend[N];
  int   m_ptr, m_ch, m_left;
  bit   m_v, m_ack, mon_en;
  int   exp_q[$];
  int   n_chk = 0, n_pass = 0;
  logic [3:0] el, re, rm;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_lat[i]  = 1'b0;
      m_pend[i] = 1'b0;
    end
    m_ptr = 0; m_ch = 0; m_v = 1'b0; m_ack = 1'b0; m_left = 0;
    exp_q.delete();
  endfunction
  // one clock of the reference behaviour, from the inputs the DUT just sampled
  task automatic model_step();
    bit set[N];
    bit old[N];
    int g;
    if (!reset_n) begin
      m_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      set[i] = err_in[i] && !err_mask[i];
      old[i] = m_lat[i];
      if (set[i]) m_lat[i] = 1'b1;
      else if (clr_req && int'(clr_ch) == i) m_lat[i] = 1'b0;
    end
    if (m_v && evt_ready) begin
      m_pend[m_ch] = 1'b0;
      m_ptr = (m_ch + 1) % N;
      m_v = 1'b0;
    end else if (!m_v) begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (g >= 0) begin
        m_v = 1'b1;
        m_ch = g;
        exp_q.push_back(g);
      end
    end
    for (int i = 0; i < N; i++)
      if (set[i] && !old[i]) m_pend[i] = 1'b1;
    m_ack = clr_req;
    if (m_left > 0) m_left--;
    else if (lamp_test_req) m_left = TC;
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < N; i++) el[i] = m_lat[i];
      chk("latched", latched, el);
      chk("LA", LA, el | {4{m_left > 0}});
      chk("test_busy", test_busy, m_left > 0);
      chk("any_err", any_err, |el);
      chk("clr_ack", clr_ack, m_ack);
      chk("evt_valid", evt_valid, m_v);
      if (m_v) chk("evt_ch_stable", evt_ch, m_ch);
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL evt_unexpected: got ch %0d expected no event at %0t", evt_ch, $time);
        end else chk("evt_order", evt_ch, exp_q.pop_front());
      end
    end
  end
  task automatic cyc(input logic [3:0] e, input logic [3:0] m, input logic lt, input logic c,
                     input logic [1:0] cc, input logic r);
    err_in = e; err_mask = m; lamp_test_req = lt; clr_req = c; clr_ch = cc; evt_ready = r;
    @(posedge clk);
    #1;
    model_step();
    mon_en = 1'b1;
  endtask
  task automatic idle(input int n, input logic r);
    repeat (n) cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, r);
  endtask
  initial begin
    m_reset();
    mon_en = 1'b0;
    idle(3, 1'b0);
    reset_n = 1'b1;
    idle(2, 1'b0);
    // single pulse on ch1, then held high: exactly one event
    cyc(4'b0010, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    repeat (6) cyc(4'b0010, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
    idle(3, 1'b1);
    // walk the pointer back to 0 via ch3, clear everything
    cyc(4'b1000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
    idle(4, 1'b1);
    for (int c = 0; c < N; c++) cyc(4'b0000, 4'b0000, 1'b0, 1'b1, 2'(c), 1'b1);
    // simultaneous ch0/ch1/ch3, then ch0 re-raised after clear
    cyc(4'b1011, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
    idle(8, 1'b1);
    cyc(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b1);
    cyc(4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
    idle(6, 1'b1);
    // host stalls with ch2 pending, clear ch2 meanwhile
    cyc(4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    idle(4, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b0);
    idle(5, 1'b0);
    idle(4, 1'b1);
    // set/clear collision on ch0, masked ch3
    cyc(4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b1);
    cyc(4'b1000, 4'b1000, 1'b0, 1'b0, 2'd0, 1'b1);
    idle(4, 1'b1);
    // lamp test with an ignored second request
    cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b1);
    idle(4, 1'b1);
    cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b1);
    idle(16, 1'b1);
    // reset in the middle of a lamp test with ch2 latched and an event outstanding
    cyc(4'b0100, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);
    idle(4, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("rst_latched", latched, 0);
    chk("rst_LA", LA, 0);
    chk("rst_test_busy", test_busy, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_any_err", any_err, 0);
    chk("rst_clr_ack", clr_ack, 0);
    m_reset();
    idle(2, 1'b0);
    reset_n = 1'b1;
    idle(2, 1'b1);
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        re[i] = ($urandom_range(0, 7) == 0);
        rm[i] = ($urandom_range(0, 3) == 0);
      end
      cyc(re, rm, $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
          2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
    end
    idle(20, 1'b1);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
